// File: rtl/apb_fifo_bridge.sv
// apb_fifo_bridge: APB slave with TX/RX byte-stream FIFOs; define APB_FIFO_IRQ_EN for the registered interrupt
module apb_fifo_bridge_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  drop
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count[DEPTH_LOG2];
  assign empty = count == '0;
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign drop = push & !do_push;
  assign head = mem[rd_ptr];
  always_ff @(posedge PCLK)
    if (do_push & !flush & !PRESET) mem[wr_ptr] <= wdata;
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
    end
endmodule

module apb_fifo_bridge #(
  parameter int DATA_W = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [3:0]        PADDR,
  input  logic [31:0]       PWDATA,
  input  logic              PWRITE,
  input  logic              PENABLE,
  input  logic              PSEL,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              irq
);
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_drop, rx_drop;
  logic [DATA_W-1:0] rx_head;
  logic capture, complete;
  logic lat_push, lat_ovf, lat_pop, lat_udf, lat_ctrl;
  logic ctrl_wr, tx_flush, rx_flush, clr;
  logic rx_ovf, tx_ovf, rx_udf;
  logic [7:0] thr_raw, thr;
  logic wm, irq_rx_en, irq_tx_en;
  logic [31:0] status, ctrl_rd, rd_val;
  logic unused;
  assign unused = ^{PADDR[1:0], PWDATA};
  assign capture = PSEL & PENABLE & !PREADY;
  assign complete = PSEL & PENABLE & PREADY;
  assign ctrl_wr = complete & lat_ctrl;
  assign tx_flush = ctrl_wr & PWDATA[0];
  assign rx_flush = ctrl_wr & PWDATA[1];
  assign clr = ctrl_wr & PWDATA[4];
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign thr = thr_raw == 8'd0 ? 8'd1 : thr_raw;
  assign wm = 8'(rx_count) >= thr;
  assign status = {8'd0, 8'(rx_count), 8'(tx_count), wm, rx_udf, tx_ovf, rx_ovf,
                   rx_empty, rx_full, tx_empty, tx_full};
  assign ctrl_rd = {16'd0, thr_raw, 4'd0, irq_tx_en, irq_rx_en, 2'd0};
  assign rd_val = PADDR[3:2] == 2'd0 ? status :
                  PADDR[3:2] == 2'd2 ? (rx_empty ? 32'd0 : 32'(rx_head)) :
                  PADDR[3:2] == 2'd3 ? ctrl_rd : 32'd0;
  apb_fifo_bridge_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
    .PCLK(PCLK), .PRESET(PRESET), .push(complete & lat_push), .pop(tx_ready),
    .flush(tx_flush), .wdata(PWDATA[DATA_W-1:0]), .head(tx_data), .count(tx_count),
    .full(tx_full), .empty(tx_empty), .drop(tx_drop)
  );
  apb_fifo_bridge_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
    .PCLK(PCLK), .PRESET(PRESET), .push(rx_valid), .pop(complete & lat_pop),
    .flush(rx_flush), .wdata(rx_data), .head(rx_head), .count(rx_count),
    .full(rx_full), .empty(rx_empty), .drop(rx_drop)
  );
  // side-effect decisions are frozen at the wait-state edge and committed on completion
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
      {lat_push, lat_ovf, lat_pop, lat_udf, lat_ctrl} <= '0;
    end else begin
      PREADY <= capture;
      if (capture) begin
        PRDATA <= PWRITE ? 32'd0 : rd_val;
        lat_push <= PWRITE & (PADDR[3:2] == 2'd1) & !tx_full;
        lat_ovf <= PWRITE & (PADDR[3:2] == 2'd1) & tx_full;
        lat_pop <= !PWRITE & (PADDR[3:2] == 2'd2) & !rx_empty;
        lat_udf <= !PWRITE & (PADDR[3:2] == 2'd2) & rx_empty;
        lat_ctrl <= PWRITE & (PADDR[3:2] == 2'd3);
      end
    end
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      {rx_ovf, tx_ovf, rx_udf} <= '0;
      thr_raw <= '0;
    end else begin
      rx_ovf <= (rx_ovf & !clr) | rx_drop;
      tx_ovf <= (tx_ovf & !clr) | (complete & lat_ovf) | tx_drop;
      rx_udf <= (rx_udf & !clr) | (complete & lat_udf);
      thr_raw <= ctrl_wr ? PWDATA[15:8] : thr_raw;
    end
`ifdef APB_FIFO_IRQ_EN
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      {irq_tx_en, irq_rx_en} <= '0;
      irq <= 1'b0;
    end else begin
      {irq_tx_en, irq_rx_en} <= ctrl_wr ? PWDATA[3:2] : {irq_tx_en, irq_rx_en};
      irq <= (irq_rx_en & wm) | (irq_tx_en & tx_empty) | rx_ovf | tx_ovf | rx_udf;
    end
`else
  assign irq_rx_en = 1'b0;
  assign irq_tx_en = 1'b0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_apb_fifo_bridge.sv
// tb_apb_fifo_bridge: directed self-checking bench for apb_fifo_bridge
module tb_apb_fifo_bridge;
  logic PCLK = 1'b0, PRESET = 1'b1;
  logic [3:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic PWRITE, PENABLE, PSEL, PREADY;
  logic tx_valid, tx_ready, rx_valid, rx_ready, irq;
  logic [7:0] tx_data, rx_data;
  logic [31:0] r;
  int total = 0, bad = 0;
`ifdef APB_FIFO_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h0000_030C;
`else
  localparam logic [31:0] CTRL_RB = 32'h0000_0300;
`endif
  always #5 PCLK = ~PCLK;
  apb_fifo_bridge #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                     input logic rxp, output logic [31:0] rd);
    int n;
    @(negedge PCLK);
    PSEL = 1; PWRITE = wr; PADDR = a; PWDATA = wd; PENABLE = 0;
    @(negedge PCLK);
    PENABLE = 1;
    chk("wait_state", PREADY, 0);
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!PREADY && n < 4);
    chk("pready", PREADY, 1);
    rd = PRDATA;
    if (rxp) begin
      rx_valid = 1;
      rx_data = 8'hC0;
    end
    @(negedge PCLK);
    chk("pready_drop", PREADY, 0);
    PSEL = 0; PENABLE = 0; rx_valid = 0;
  endtask
  task automatic apb_wr(input logic [3:0] a, input logic [31:0] wd, input logic rxp = 0);
    logic [31:0] d;
    apb(1'b1, a, wd, rxp, d);
  endtask
  task automatic apb_rd(input logic [3:0] a, output logic [31:0] rd, input logic rxp = 0);
    apb(1'b0, a, 32'd0, rxp, rd);
  endtask
  task automatic rx_push(input logic [7:0] d);
    @(negedge PCLK);
    rx_valid = 1;
    rx_data = d;
    @(negedge PCLK);
    rx_valid = 0;
  endtask
  initial begin
    PADDR = 0; PWDATA = 0; PWRITE = 0; PENABLE = 0; PSEL = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    repeat (3) @(negedge PCLK);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_pready", PREADY, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_irq", irq, 0);
    PRESET = 0;
    apb_rd(4'h0, r);
    chk("status_rst", r, 32'h0000_000A);
    apb_wr(4'h4, 32'hA5);
    apb_wr(4'h4, 32'h3C);
    chk("tx_valid", tx_valid, 1);
    chk("tx_head", tx_data, 8'hA5);
    apb_rd(4'h0, r);
    chk("status_tx2", r, 32'h0000_0208);
    @(negedge PCLK);
    tx_ready = 1;
    chk("drain0", tx_data, 8'hA5);
    @(negedge PCLK);
    chk("drain1", tx_data, 8'h3C);
    @(negedge PCLK);
    tx_ready = 0;
    chk("tx_drained", tx_valid, 0);
    apb_rd(4'h4, r);
    chk("txdata_rd", r, 0);
    for (int i = 0; i < 17; i++) apb_wr(4'h4, 32'h40 + i);
    apb_rd(4'h0, r);
    chk("status_txovf", r, 32'h0000_1029);
    @(negedge PCLK);
    tx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("tx_order", tx_data, 32'h40 + i);
      @(negedge PCLK);
    end
    tx_ready = 0;
    chk("tx_17th_absent", tx_valid, 0);
    apb_rd(4'h0, r);
    chk("status_txovf_sticky", r, 32'h0000_002A);
    apb_wr(4'hC, 32'h10);
    apb_rd(4'h0, r);
    chk("status_clr", r, 32'h0000_000A);
    for (int i = 0; i < 16; i++) rx_push(8'h11 + 8'(i));
    rx_push(8'h99);
    chk("rx_ready_full", rx_ready, 0);
    apb_rd(4'h0, r);
    chk("status_rxovf", r, 32'h0010_0096);
    for (int i = 0; i < 16; i++) begin
      apb_rd(4'h8, r);
      chk("rx_order", r, 32'h11 + i);
    end
    apb_rd(4'h8, r);
    chk("rx_underflow_data", r, 0);
    apb_rd(4'h0, r);
    chk("status_udf", r, 32'h0000_005A);
    apb_wr(4'hC, 32'h10);
    for (int i = 0; i < 12; i++) rx_push(8'h60 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      apb_rd(4'h8, r);
      chk("wrap_a", r, 32'h60 + i);
    end
    for (int i = 0; i < 8; i++) rx_push(8'h80 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      apb_rd(4'h8, r);
      chk("wrap_b", r, 32'h80 + i);
    end
    for (int i = 0; i < 16; i++) rx_push(8'hB0 + 8'(i));
    apb_rd(4'h8, r, 1'b1);
    chk("simul_pop", r, 32'hB0);
    apb_rd(4'h0, r);
    chk("status_simul", r, 32'h0010_0086);
    for (int i = 1; i < 16; i++) begin
      apb_rd(4'h8, r);
      chk("simul_order", r, 32'hB0 + i);
    end
    apb_rd(4'h8, r);
    chk("simul_last", r, 32'hC0);
    apb_rd(4'h0, r);
    chk("status_simul_empty", r, 32'h0000_000A);
    apb_wr(4'h4, 32'h01);
    apb_wr(4'h4, 32'h02);
    apb_wr(4'hC, 32'h01);
    chk("tx_flush", tx_valid, 0);
    for (int i = 0; i < 3; i++) rx_push(8'h70 + 8'(i));
    apb_wr(4'hC, 32'h02);
    apb_rd(4'h0, r);
    chk("rx_flush", r, 32'h0000_000A);
    apb_wr(4'hC, 32'h030C);
    apb_rd(4'hC, r);
    chk("ctrl_rb", r, CTRL_RB);
    apb_wr(4'hC, 32'h0300);
    rx_push(8'h01);
    rx_push(8'h02);
    apb_rd(4'h0, r);
    chk("wm_below", r, 32'h0002_0002);
    rx_push(8'h03);
    apb_rd(4'h0, r);
    chk("wm_at", r, 32'h0003_0082);
    chk("irq_off", irq, 0);
    apb_wr(4'hC, 32'h0302);
    apb_rd(4'h0, r);
    chk("wm_flushed", r, 32'h0000_000A);
`ifdef APB_FIFO_IRQ_EN
    apb_wr(4'hC, 32'h0304);
    rx_push(8'h01);
    rx_push(8'h02);
    rx_push(8'h03);
    chk("irq_lag", irq, 0);
    @(negedge PCLK);
    chk("irq_rise", irq, 1);
    apb_wr(4'hC, 32'h0002, 1'b1);
    chk("irq_hold", irq, 1);
    @(negedge PCLK);
    chk("irq_fall", irq, 0);
    apb_rd(4'h0, r);
    chk("flush_beats_push", r, 32'h0000_000A);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
